// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad lock and its sibling blocks
// (scan/debounce decoder, LED/actuator logic).
package keypad_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } lock_state_e;

    localparam int DIGIT_W_DEFAULT = 4;

    // Function keys produced by the keyboard decoder; never valid password digits.
    localparam logic [DIGIT_W_DEFAULT-1:0] KEY_ENTER = 4'hE;
    localparam logic [DIGIT_W_DEFAULT-1:0] KEY_CLEAR = 4'hC;

    // Width needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/keypad_lock_cycle_timer.sv
// Loadable down-counter: expire pulses on the enabled cycle that would take
// the count from 1 to 0. A load value of 0 never expires.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expire
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    // A load in the same cycle wins, so a late key restarts rather than expires.
    assign expire = enable && !load && (count_reg == WIDTH'(1));

endmodule

// File: rtl/keypad_lock.sv
// Keypad combination lock: compares a PW_LEN-digit key sequence against a
// loadable password, with failure lockout, inter-key timeout and auto-relock.
module keypad_lock
    import keypad_pkg::*;
#(
    parameter int                           DIGIT_W     = DIGIT_W_DEFAULT,
    parameter int                           PW_LEN      = 4,
    parameter logic [PW_LEN*DIGIT_W-1:0]    PW_DEFAULT  = 16'h1234,
    parameter int                           MAX_FAIL    = 3,
    parameter int                           LOCK_CYCLES = 1000,
    parameter int                           KEY_TIMEOUT = 5000,
    parameter int                           OPEN_CYCLES = 10000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                key_valid,
    input  logic [DIGIT_W-1:0]                  key_code,
    input  logic                                relock,
    input  logic                                pw_we,
    input  logic [PW_LEN*DIGIT_W-1:0]           pw_data,
    output logic                                unlocked,
    output logic                                locked_out,
    output logic                                fail_pulse,
    output logic [clog2_min1(PW_LEN+1)-1:0]     digit_cnt,
    output logic [clog2_min1(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int PW_W = PW_LEN * DIGIT_W;
    localparam int DC_W = clog2_min1(PW_LEN + 1);
    localparam int FC_W = clog2_min1(MAX_FAIL + 1);
    localparam int KT_W = clog2_min1(KEY_TIMEOUT + 1);
    localparam int OT_W = clog2_min1(OPEN_CYCLES + 1);
    localparam int LT_W = clog2_min1(LOCK_CYCLES + 1);

    lock_state_e        state_reg, state_next;
    logic [PW_W-1:0]    pw_reg, pw_next;
    logic [DC_W-1:0]    digit_cnt_reg, digit_cnt_next;
    logic [FC_W-1:0]    fail_cnt_reg, fail_cnt_next;
    logic               mismatch_reg, mismatch_next;
    logic               unlocked_reg, unlocked_next;
    logic               locked_out_reg, locked_out_next;
    logic               fail_pulse_reg, fail_pulse_next;

    logic [PW_LEN-1:0]  digit_hit;
    logic               key_accept;
    logic               key_match;
    logic               last_key;
    logic               attempt_ok;
    logic               attempt_fail;
    logic [FC_W-1:0]    fail_cnt_inc;
    logic               lockout_hit;
    logic               key_expire;
    logic               open_expire;
    logic               lock_expire;

    // Digit 0 lives in the most significant slot of the password word.
    genvar gi;
    generate
        for (gi = 0; gi < PW_LEN; gi++) begin : g_digit
            assign digit_hit[gi] = (digit_cnt_reg == DC_W'(gi)) &&
                                   (key_code == pw_reg[(PW_LEN-1-gi)*DIGIT_W +: DIGIT_W]);
        end
    endgenerate

    assign key_accept   = (state_reg == ENTRY) && key_valid;
    assign key_match    = |digit_hit;
    assign last_key     = (digit_cnt_reg == DC_W'(PW_LEN - 1));
    assign attempt_ok   = key_accept && last_key && !mismatch_reg && key_match;
    assign attempt_fail = key_accept && last_key && !(!mismatch_reg && key_match);
    assign fail_cnt_inc = (fail_cnt_reg == FC_W'(MAX_FAIL)) ? fail_cnt_reg
                                                            : fail_cnt_reg + FC_W'(1);
    assign lockout_hit  = attempt_fail && (fail_cnt_inc == FC_W'(MAX_FAIL));

    cycle_timer #(.WIDTH(KT_W)) u_key_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (key_accept),
        .load_value (KT_W'(KEY_TIMEOUT)),
        .enable     ((state_reg == ENTRY) && (digit_cnt_reg != '0)),
        .expire     (key_expire)
    );

    cycle_timer #(.WIDTH(OT_W)) u_open_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (attempt_ok),
        .load_value (OT_W'(OPEN_CYCLES)),
        .enable     (state_reg == OPEN),
        .expire     (open_expire)
    );

    cycle_timer #(.WIDTH(LT_W)) u_lock_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lockout_hit),
        .load_value (LT_W'(LOCK_CYCLES)),
        .enable     (state_reg == LOCKOUT),
        .expire     (lock_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ENTRY;
            pw_reg         <= PW_DEFAULT;
            digit_cnt_reg  <= '0;
            fail_cnt_reg   <= '0;
            mismatch_reg   <= 1'b0;
            unlocked_reg   <= 1'b0;
            locked_out_reg <= 1'b0;
            fail_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pw_reg         <= pw_next;
            digit_cnt_reg  <= digit_cnt_next;
            fail_cnt_reg   <= fail_cnt_next;
            mismatch_reg   <= mismatch_next;
            unlocked_reg   <= unlocked_next;
            locked_out_reg <= locked_out_next;
            fail_pulse_reg <= fail_pulse_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ENTRY: begin
                if (attempt_ok) begin
                    state_next = OPEN;
                end else if (lockout_hit) begin
                    state_next = LOCKOUT;
                end
            end
            OPEN: begin
                if (relock || open_expire) begin
                    state_next = ENTRY;
                end
            end
            LOCKOUT: begin
                if (lock_expire) begin
                    state_next = ENTRY;
                end
            end
            default: state_next = ENTRY;
        endcase
    end

    // Attempt bookkeeping; the mismatch flag is sticky so the error position stays hidden.
    always_comb begin
        pw_next        = pw_reg;
        digit_cnt_next = digit_cnt_reg;
        fail_cnt_next  = fail_cnt_reg;
        mismatch_next  = mismatch_reg;
        if (state_reg == ENTRY) begin
            if (key_accept) begin
                if (last_key) begin
                    digit_cnt_next = '0;
                    mismatch_next  = 1'b0;
                    fail_cnt_next  = attempt_ok ? '0 : fail_cnt_inc;
                end else begin
                    digit_cnt_next = digit_cnt_reg + DC_W'(1);
                    mismatch_next  = mismatch_reg || !key_match;
                end
            end else if (key_expire) begin
                digit_cnt_next = '0;
                mismatch_next  = 1'b0;
            end
        end
        if ((state_reg == OPEN) && pw_we) begin
            pw_next = pw_data;
        end
        if ((state_reg == LOCKOUT) && lock_expire) begin
            fail_cnt_next = '0;
        end
    end

    always_comb begin
        unlocked_next   = (state_next == OPEN);
        locked_out_next = (state_next == LOCKOUT);
        fail_pulse_next = attempt_fail;
    end

    assign unlocked   = unlocked_reg;
    assign locked_out = locked_out_reg;
    assign fail_pulse = fail_pulse_reg;
    assign digit_cnt  = digit_cnt_reg;
    assign fail_cnt   = fail_cnt_reg;

endmodule
